bird_sprite_ctrl: RTL and testbench

Controls the player bird: a per-frame physics/state machine for vertical position and game state, plus a per-pixel pipeline that addresses the 16x16 bird sprite ROM. It handles the ROM's one-cycle read latency and its transparency key (12'h0FF), and it delivers an aligned colour/coverage pair to the pixel mixer. It sits between the VGA timing generator, the input debouncer, the pipe/collision logic and bird_rom.

---
 rtl/bird_sprite_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_bird_sprite_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/bird_sprite_ctrl.sv
// Purpose : player-bird controller; per-frame physics/game FSM plus per-pixel sprite ROM addressing.
// Latency : pix_x/pix_y -> bird_on/bird_rgb is exactly 1 clk; bird_y/state update on the clk edge of frame_tick.
// Backpres: none; the pixel path is a free-running pipeline and the FSM reacts to single-cycle pulses.
//
// Ports:
//   i_clk, i_reset         : clock and synchronous active-high reset
//   i_frame_tick           : one pulse per frame (in vblank), advances the physics
//   i_flap, i_start, i_hit : one-cycle control pulses from debouncer / collision logic
//   i_video_on, i_pix_x/y  : current raster position from the VGA timing generator
//   o_rom_row, o_rom_col   : sprite ROM address; i_rom_pixel returns one cycle later
//   o_bird_on, o_bird_rgb  : aligned coverage/colour to the pixel mixer
//   o_bird_y, o_state,
//   o_dead                 : game status for pipe/collision logic and the display

module bird_sprite_ctrl #(
    parameter int BIRD_X   = 160,
    parameter int START_Y  = 232,
    parameter int GROUND_Y = 440,
    parameter int GRAVITY  = 1,
    parameter int FLAP_VEL = -6,
    parameter int MAX_FALL = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_frame_tick,
    input  logic        i_flap,
    input  logic        i_start,
    input  logic        i_hit,
    input  logic        i_video_on,
    input  logic [9:0]  i_pix_x,
    input  logic [9:0]  i_pix_y,
    output logic [3:0]  o_rom_row,
    output logic [3:0]  o_rom_col,
    input  logic [11:0] i_rom_pixel,
    output logic        o_bird_on,
    output logic [11:0] o_bird_rgb,
    output logic [9:0]  o_bird_y,
    output logic [1:0]  o_state,
    output logic        o_dead
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_FALL = 2'd2,
        S_DEAD = 2'd3
    } state_t;

    localparam logic [9:0]         C_BIRD_X   = 10'(BIRD_X);
    localparam logic [9:0]         C_START_Y  = 10'(START_Y);
    localparam logic [9:0]         C_LAND_Y   = 10'(GROUND_Y - 16);
    localparam logic signed [10:0] C_LAND_Y_S = 11'(GROUND_Y - 16);
    localparam logic signed [6:0]  C_GRAV     = 7'(GRAVITY);
    localparam logic signed [6:0]  C_MAX_FALL = 7'(MAX_FALL);
    localparam logic signed [5:0]  C_FLAP_VEL = 6'(FLAP_VEL);
    localparam logic [11:0]        C_KEY      = 12'h0FF;

    state_t             r_state;
    logic [9:0]         r_bird_y;
    logic signed [5:0]  r_vel;
    logic               r_flap_pending;
    logic               r_in_box_d;

    // ------------------------------------------------------------------
    // Physics datapath
    // ------------------------------------------------------------------
    logic signed [6:0]  w_vel_inc;
    logic signed [5:0]  w_vel_grav;
    logic signed [5:0]  w_vel_next;
    logic               w_flap_eff;
    logic signed [10:0] w_y_sum;
    logic               w_y_above_top;
    logic               w_y_on_ground;

    // A flap arriving in the same cycle as the tick is honoured for that tick.
    assign w_flap_eff = r_flap_pending | i_flap;

    always_comb begin
        // One extra bit so the gravity add cannot wrap before saturation.
        w_vel_inc  = {r_vel[5], r_vel} + C_GRAV;
        w_vel_grav = (w_vel_inc > C_MAX_FALL) ? C_MAX_FALL[5:0] : w_vel_inc[5:0];
        // FALL never flaps, so only PLAY can select the flap velocity.
        w_vel_next = ((r_state == S_PLAY) && w_flap_eff) ? C_FLAP_VEL : w_vel_grav;
        w_y_sum    = $signed({1'b0, r_bird_y}) + $signed({{5{w_vel_next[5]}}, w_vel_next});
        w_y_above_top = (w_y_sum < 11'sd0);
        w_y_on_ground = (w_y_sum >= C_LAND_Y_S);
    end

    // ------------------------------------------------------------------
    // Pixel stage 0: box test and ROM addressing
    // ------------------------------------------------------------------
    logic [9:0] w_dx;
    logic [9:0] w_dy;
    logic       w_in_box;

    // Differences are only meaningful when the lower bound holds, so the
    // range checks are written as (>= lower) & (offset <= 15), which is
    // immune to the modulo-1024 wrap of the subtraction.
    assign w_dx     = i_pix_x - C_BIRD_X;
    assign w_dy     = i_pix_y - r_bird_y;
    assign w_in_box = i_video_on
                    & (i_pix_x >= C_BIRD_X) & (w_dx <= 10'd15)
                    & (i_pix_y >= r_bird_y) & (w_dy <= 10'd15);

    // Address is driven unconditionally; coverage is gated later by in_box_d.
    assign o_rom_col = w_dx[3:0];
    assign o_rom_row = w_dy[3:0];

    // ------------------------------------------------------------------
    // Game FSM and stage-1 pipeline register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= S_IDLE;
            r_bird_y       <= C_START_Y;
            r_vel          <= 6'sd0;
            r_flap_pending <= 1'b0;
            r_in_box_d     <= 1'b0;
        end else begin
            r_in_box_d <= w_in_box;

            case (r_state)
                S_IDLE: begin
                    // A flap that starts the game is remembered so the first
                    // tick applies the flap velocity.
                    r_flap_pending <= i_flap;
                    if (i_flap || i_start) begin
                        r_state <= S_PLAY;
                    end
                end

                S_PLAY: begin
                    if (i_hit) begin
                        // Collision wins over a coincident tick or flap.
                        r_state        <= S_FALL;
                        r_flap_pending <= 1'b0;
                    end else if (i_frame_tick) begin
                        r_flap_pending <= 1'b0;
                        if (w_y_on_ground) begin
                            r_bird_y <= C_LAND_Y;
                            r_vel    <= 6'sd0;
                            r_state  <= S_DEAD;
                        end else if (w_y_above_top) begin
                            r_bird_y <= 10'd0;
                            r_vel    <= 6'sd0;
                        end else begin
                            r_bird_y <= w_y_sum[9:0];
                            r_vel    <= w_vel_next;
                        end
                    end else if (i_flap) begin
                        r_flap_pending <= 1'b1;
                    end
                end

                S_FALL: begin
                    r_flap_pending <= 1'b0;
                    if (i_frame_tick) begin
                        if (w_y_on_ground) begin
                            r_bird_y <= C_LAND_Y;
                            r_vel    <= 6'sd0;
                            r_state  <= S_DEAD;
                        end else if (w_y_above_top) begin
                            r_bird_y <= 10'd0;
                            r_vel    <= 6'sd0;
                        end else begin
                            r_bird_y <= w_y_sum[9:0];
                            r_vel    <= w_vel_next;
                        end
                    end
                end

                S_DEAD: begin
                    r_flap_pending <= 1'b0;
                    if (i_start) begin
                        r_state  <= S_IDLE;
                        r_bird_y <= C_START_Y;
                        r_vel    <= 6'sd0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pixel stage 1: ROM data arrives now, aligned with r_in_box_d
    // ------------------------------------------------------------------
    assign o_bird_on  = r_in_box_d & (i_rom_pixel != C_KEY);
    assign o_bird_rgb = o_bird_on ? i_rom_pixel : 12'h000;

    assign o_bird_y = r_bird_y;
    assign o_state  = r_state;
    assign o_dead   = (r_state == S_DEAD);

endmodule

// File: tb/tb_bird_sprite_ctrl.sv
module tb_bird_sprite_ctrl;

    logic        clk;
    logic        reset;
    logic        frame_tick;
    logic        flap;
    logic        start;
    logic        hit;
    logic        video_on;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [3:0]  rom_row;
    logic [3:0]  rom_col;
    logic [11:0] rom_pixel;
    logic        bird_on;
    logic [11:0] bird_rgb;
    logic [9:0]  bird_y;
    logic [1:0]  state;
    logic        dead;

    int errors = 0;
    int checks = 0;

    bird_sprite_ctrl dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_frame_tick (frame_tick),
        .i_flap       (flap),
        .i_start      (start),
        .i_hit        (hit),
        .i_video_on   (video_on),
        .i_pix_x      (pix_x),
        .i_pix_y      (pix_y),
        .o_rom_row    (rom_row),
        .o_rom_col    (rom_col),
        .i_rom_pixel  (rom_pixel),
        .o_bird_on    (bird_on),
        .o_bird_rgb   (bird_rgb),
        .o_bird_y     (bird_y),
        .o_state      (state),
        .o_dead       (dead)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sprite ROM stand-in with one cycle of read latency.
    // Diagonal is transparent, upper triangle white, lower triangle encodes row/col.
    function automatic logic [11:0] rom_fn(input logic [3:0] r, input logic [3:0] c);
        if (r == c)     return 12'h0FF;
        else if (r < c) return 12'hFFF;
        else            return {r, c, 4'h0};
    endfunction

    always_ff @(posedge clk) rom_pixel <= rom_fn(rom_row, rom_col);

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", nm, act, exp);
        end
    endtask

    // One-cycle pulse of the control inputs; samples are taken #1 after the edge.
    task automatic pulse(input logic t, input logic f, input logic s, input logic h);
        @(negedge clk);
        frame_tick = t; flap = f; start = s; hit = h;
        @(posedge clk);
        #1;
        frame_tick = 0; flap = 0; start = 0; hit = 0;
    endtask

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        vid;
        logic [3:0]  row;
        logic [3:0]  col;
        logic        on;
        logic [11:0] rgb;
    } vec_t;

    typedef struct {
        int          idx;
        logic        on;
        logic [11:0] rgb;
    } exp_t;

    vec_t vecs[12];
    exp_t sb[$];

    int   my, mv;
    logic mdead;

    initial begin
        // bird_y is 232 while these are applied
        vecs[0]  = '{10'd165, 10'd235, 1'b1, 4'd3,  4'd5,  1'b1, 12'hFFF};
        vecs[1]  = '{10'd160, 10'd232, 1'b1, 4'd0,  4'd0,  1'b0, 12'h000};
        vecs[2]  = '{10'd176, 10'd232, 1'b1, 4'd0,  4'd0,  1'b0, 12'h000};
        vecs[3]  = '{10'd165, 10'd235, 1'b0, 4'd3,  4'd5,  1'b0, 12'h000};
        vecs[4]  = '{10'd175, 10'd247, 1'b1, 4'd15, 4'd15, 1'b0, 12'h000};
        vecs[5]  = '{10'd170, 10'd240, 1'b1, 4'd8,  4'd10, 1'b1, 12'hFFF};
        vecs[6]  = '{10'd162, 10'd245, 1'b1, 4'd13, 4'd2,  1'b1, 12'hD20};
        vecs[7]  = '{10'd159, 10'd240, 1'b1, 4'd8,  4'd15, 1'b0, 12'h000};
        vecs[8]  = '{10'd167, 10'd231, 1'b1, 4'd15, 4'd7,  1'b0, 12'h000};
        vecs[9]  = '{10'd168, 10'd248, 1'b1, 4'd0,  4'd8,  1'b0, 12'h000};
        vecs[10] = '{10'd174, 10'd233, 1'b1, 4'd1,  4'd14, 1'b1, 12'hFFF};
        vecs[11] = '{10'd161, 10'd246, 1'b1, 4'd14, 4'd1,  1'b1, 12'hE10};

        reset = 1; frame_tick = 0; flap = 0; start = 0; hit = 0;
        video_on = 0; pix_x = 0; pix_y = 0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 0;
        @(posedge clk); #1;
        chk("rst_state", state, 0);
        chk("rst_y", bird_y, 232);
        chk("rst_dead", dead, 0);
        chk("rst_on", bird_on, 0);
        chk("rst_rgb", bird_rgb, 0);

        // ---------------- pixel pipeline table ----------------
        for (int i = 0; i <= 12; i++) begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk($sformatf("pix%0d_on", e.idx), bird_on, e.on);
                chk($sformatf("pix%0d_rgb", e.idx), bird_rgb, e.rgb);
            end
            if (i < 12) begin
                pix_x = vecs[i].x; pix_y = vecs[i].y; video_on = vecs[i].vid;
                #1;
                chk($sformatf("pix%0d_row", i), rom_row, vecs[i].row);
                chk($sformatf("pix%0d_col", i), rom_col, vecs[i].col);
                sb.push_back('{i, vecs[i].on, vecs[i].rgb});
            end
        end
        video_on = 0;
        chk("sb_empty", sb.size(), 0);

        // ---------------- flap from IDLE, then 3 ticks ----------------
        pulse(0, 1, 0, 0);
        chk("flap_state", state, 1);
        chk("flap_hold_y", bird_y, 232);
        pulse(1, 0, 0, 0); chk("flap_t1", bird_y, 226);
        pulse(1, 0, 0, 0); chk("flap_t2", bird_y, 221);
        pulse(1, 0, 0, 0); chk("flap_t3", bird_y, 217);
        pulse(0, 0, 0, 0); chk("no_tick_hold", bird_y, 217);

        // ---------------- reset mid-PLAY, with bird pixel in flight -----
        @(negedge clk);
        pix_x = 165; pix_y = 220; video_on = 1;
        reset = 1; frame_tick = 1; flap = 1;
        @(posedge clk); #1;
        reset = 0; frame_tick = 0; flap = 0; video_on = 0;
        chk("mrst_state", state, 0);
        chk("mrst_y", bird_y, 232);
        chk("mrst_dead", dead, 0);
        chk("mrst_on", bird_on, 0);
        chk("mrst_rgb", bird_rgb, 0);

        // ---------------- free fall in PLAY to the ground ----------------
        pulse(0, 0, 1, 0);
        chk("start_state", state, 1);
        my = 232; mv = 0; mdead = 0;
        for (int i = 0; i < 30; i++) begin
            pulse(1, 0, 0, 0);
            if (!mdead) begin
                mv = (mv + 1 > 8) ? 8 : mv + 1;
                my = my + mv;
                if (my >= 424) begin my = 424; mv = 0; mdead = 1; end
            end
            chk($sformatf("fall%0d_y", i), bird_y, my);
            chk($sformatf("fall%0d_st", i), state, mdead ? 3 : 1);
        end
        chk("land_dead", dead, 1);
        pulse(1, 1, 0, 1);
        chk("dead_ignore_st", state, 3);
        chk("dead_ignore_y", bird_y, 424);
        pulse(0, 0, 1, 0);
        chk("restart_st", state, 0);
        chk("restart_y", bird_y, 232);
        chk("restart_dead", dead, 0);

        // ---------------- hit + flap + tick together ----------------
        pulse(0, 0, 1, 0);
        pulse(1, 0, 0, 0); chk("pre_hit_y1", bird_y, 233);
        pulse(1, 0, 0, 0); chk("pre_hit_y2", bird_y, 235);
        pulse(1, 1, 0, 1);
        chk("hit_state", state, 2);
        chk("hit_y_hold", bird_y, 235);
        my = 235; mv = 2; mdead = 0;
        for (int i = 0; i < 30; i++) begin
            pulse(1, 1, 0, 0);
            if (!mdead) begin
                mv = (mv + 1 > 8) ? 8 : mv + 1;
                my = my + mv;
                if (my >= 424) begin my = 424; mv = 0; mdead = 1; end
            end
            chk($sformatf("hfall%0d_y", i), bird_y, my);
            chk($sformatf("hfall%0d_st", i), state, mdead ? 3 : 2);
        end
        pulse(0, 0, 1, 0);
        chk("restart2_st", state, 0);

        // ---------------- top clamp ----------------
        pulse(0, 1, 0, 0);
        pulse(1, 0, 0, 0); chk("climb0_y", bird_y, 226);
        my = 226;
        for (int i = 0; i < 37; i++) begin
            if (i % 2 == 0) begin
                pulse(0, 1, 0, 0);
                pulse(1, 0, 0, 0);
            end else begin
                pulse(1, 1, 0, 0);
            end
            my = my - 6;
        end
        chk("climb_y4", bird_y, my);
        chk("climb_y4_abs", bird_y, 4);
        pulse(1, 1, 0, 0);
        chk("top_clamp_y", bird_y, 0);
        chk("top_clamp_st", state, 1);
        pulse(1, 0, 0, 0); chk("after_clamp_y1", bird_y, 1);
        pulse(1, 0, 0, 0); chk("after_clamp_y2", bird_y, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
